axi_sram_responder: RTL and testbench



---
 rtl/axi_sram_responder_pkg.sv | 45 ++++
 rtl/axi_sram_responder.sv | 200 ++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_responder_pkg.sv
// Shared types and helpers for the AXI-to-SRAM slave responder.
// The state encoding, response/burst codes and the per-beat address step all live here.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_sram_responder_pkg;

    localparam int IDW     = `AXI_IDS_BITS;
    localparam int SRAM_AW = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_ISSUE,
        S_R_LOAD,
        S_R_SEND,
        S_W_DATA,
        S_W_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic [3:0]         beat;
    } step_t;

    // WRAP is deliberately handled like INCR; the word address rolls over at the SRAM size.
    function automatic step_t next_step(input logic [SRAM_AW-1:0] addr,
                                        input logic [3:0]         beat,
                                        input logic [1:0]         burst);
        step_t s;
        s.beat = beat + 4'd1;
        s.addr = (burst == BURST_FIXED) ? addr : addr + SRAM_AW'(1);
        return s;
    endfunction

endpackage

// File: rtl/axi_sram_responder.sv
// AXI4 slave responder: sequences read/write bursts onto a single-port synchronous SRAM,
// one beat at a time, and returns R/B responses tagged with the slave-side ID.
module axi_sram_responder
    import axi_sram_responder_pkg::*;
(
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [IDW-1:0]     AWID,
    input  logic [31:0]        AWADDR,
    input  logic [3:0]         AWLEN,
    input  logic [2:0]         AWSIZE,
    input  logic [1:0]         AWBURST,
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [IDW-1:0]     ARID,
    input  logic [31:0]        ARADDR,
    input  logic [3:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    input  logic               ARVALID,
    output logic               ARREADY,
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    input  logic               WLAST,
    input  logic               WVALID,
    output logic               WREADY,
    output logic [IDW-1:0]     BID,
    output logic [1:0]         BRESP,
    output logic               BVALID,
    input  logic               BREADY,
    output logic [IDW-1:0]     RID,
    output logic [31:0]        RDATA,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    output logic               RVALID,
    input  logic               RREADY,
    output logic               SRAM_CS,
    output logic               SRAM_OE,
    output logic [3:0]         SRAM_WEB,
    output logic [SRAM_AW-1:0] SRAM_A,
    output logic [31:0]        SRAM_DI,
    input  logic [31:0]        SRAM_DO
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [3:0]         len_q, len_d;
    logic [1:0]         burst_q, burst_d;
    logic [3:0]         beat_q, beat_d;
    logic               err_q, err_d;
    logic               over_q, over_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rdy_q;
    step_t              nxt;

    // Byte-lane and high address bits are not meaningful for a word-wide SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[31:SRAM_AW+2], AWADDR[1:0],
                                ARADDR[31:SRAM_AW+2], ARADDR[1:0]};

    assign nxt   = next_step(addr_q, beat_q, burst_q);
    assign RDATA = rdata_q;
    assign RID   = id_q;
    assign BID   = id_q;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        err_d    = err_q;
        over_d   = over_q;
        rdata_d  = rdata_q;
        AWREADY  = 1'b0;
        ARREADY  = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        BRESP    = RESP_OKAY;
        RVALID   = 1'b0;
        RLAST    = 1'b0;
        RRESP    = RESP_OKAY;
        SRAM_CS  = 1'b0;
        SRAM_OE  = 1'b0;
        SRAM_WEB = 4'hF;
        SRAM_A   = '0;
        SRAM_DI  = '0;
        unique case (state_q)
            S_IDLE: begin
                // rdy_q keeps both READYs low until the first cycle out of reset.
                AWREADY = rdy_q;
                ARREADY = rdy_q & ~AWVALID;
                if (rdy_q && AWVALID) begin
                    id_d    = AWID;
                    addr_d  = AWADDR[SRAM_AW+1:2];
                    len_d   = AWLEN;
                    burst_d = AWBURST;
                    beat_d  = '0;
                    over_d  = 1'b0;
                    err_d   = (AWSIZE != SIZE_WORD);
                    state_d = S_W_DATA;
                end else if (rdy_q && ARVALID) begin
                    id_d    = ARID;
                    addr_d  = ARADDR[SRAM_AW+1:2];
                    len_d   = ARLEN;
                    burst_d = ARBURST;
                    beat_d  = '0;
                    over_d  = 1'b0;
                    err_d   = (ARSIZE != SIZE_WORD);
                    state_d = S_R_ISSUE;
                end
            end
            S_R_ISSUE: begin
                SRAM_CS = 1'b1;
                SRAM_OE = 1'b1;
                SRAM_A  = addr_q;
                state_d = S_R_LOAD;
            end
            S_R_LOAD: begin
                SRAM_CS = 1'b1;
                SRAM_OE = 1'b1;
                SRAM_A  = addr_q;
                rdata_d = SRAM_DO;
                state_d = S_R_SEND;
            end
            S_R_SEND: begin
                RVALID = 1'b1;
                RLAST  = (beat_q == len_q);
                RRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (RREADY) begin
                    if (beat_q == len_q) begin
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = nxt.beat;
                        addr_d  = nxt.addr;
                        state_d = S_R_ISSUE;
                    end
                end
            end
            S_W_DATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    SRAM_CS  = 1'b1;
                    SRAM_A   = addr_q;
                    SRAM_DI  = WDATA;
                    // Beats past AWLEN are swallowed without touching the array.
                    SRAM_WEB = over_q ? 4'hF : ~WSTRB;
                    beat_d   = nxt.beat;
                    addr_d   = nxt.addr;
                    if (WLAST) begin
                        err_d   = err_q | over_q | (beat_q != len_q);
                        state_d = S_W_RESP;
                    end else if (beat_q == len_q) begin
                        over_d = 1'b1;
                    end
                end
            end
            S_W_RESP: begin
                BVALID = 1'b1;
                BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (BREADY) begin
                    err_d   = 1'b0;
                    over_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            over_q  <= 1'b0;
            rdata_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            over_q  <= over_d;
            rdata_q <= rdata_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: SRAM model plus write/read/B scoreboards.
module tb_axi_sram_responder;
    import axi_sram_responder_pkg::*;

    logic               ACLK = 1'b0;
    logic               ARESETn = 1'b0;
    logic [IDW-1:0]     AWID = '0, ARID = '0;
    logic [31:0]        AWADDR = '0, ARADDR = '0;
    logic [3:0]         AWLEN = '0, ARLEN = '0;
    logic [2:0]         AWSIZE = SIZE_WORD, ARSIZE = SIZE_WORD;
    logic [1:0]         AWBURST = BURST_INCR, ARBURST = BURST_INCR;
    logic               AWVALID = 1'b0, ARVALID = 1'b0;
    logic               AWREADY, ARREADY;
    logic [31:0]        WDATA = '0;
    logic [3:0]         WSTRB = '0;
    logic               WLAST = 1'b0, WVALID = 1'b0, WREADY;
    logic [IDW-1:0]     BID, RID;
    logic [1:0]         BRESP, RRESP;
    logic               BVALID, BREADY = 1'b1;
    logic [31:0]        RDATA;
    logic               RLAST, RVALID, RREADY = 1'b1;
    logic               SRAM_CS, SRAM_OE;
    logic [3:0]         SRAM_WEB;
    logic [SRAM_AW-1:0] SRAM_A;
    logic [31:0]        SRAM_DI, SRAM_DO;

    axi_sram_responder dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .SRAM_CS(SRAM_CS), .SRAM_OE(SRAM_OE), .SRAM_WEB(SRAM_WEB), .SRAM_A(SRAM_A),
        .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [SRAM_AW-1:0] a; logic [31:0] d; logic [3:0] web; } wr_t;
    typedef struct { logic [31:0] d; logic [IDW-1:0] id; logic last; logic [1:0] resp; } rd_t;
    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_t;

    wr_t exp_wr[$];
    rd_t exp_r[$];
    b_t  exp_b[$];

    int errors = 0, checks = 0;
    int cyc = 0, cs_cnt = 0, r_cnt = 0, b_cnt = 0, b_cyc = 0, ar_cyc = 0, w_cycles = 0;
    logic [31:0] mem    [0:(1<<SRAM_AW)-1];
    logic [31:0] shadow [0:(1<<SRAM_AW)-1];
    logic [31:0] do_q = '0;
    logic [31:0] wd [0:15];
    logic [3:0]  ws [0:15];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                          input logic [3:0] web);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!web[b]) r[8*b+:8] = di[8*b+:8];
        return r;
    endfunction

    function automatic logic [SRAM_AW-1:0] step_a(input logic [SRAM_AW-1:0] a, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + SRAM_AW'(1);
    endfunction

    // Synchronous SRAM: read data appears the cycle after the address is sampled.
    assign SRAM_DO = do_q;
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (SRAM_CS === 1'b1) begin
            cs_cnt <= cs_cnt + 1;
            if (SRAM_OE) do_q <= mem[SRAM_A];
            if (SRAM_WEB != 4'hF) mem[SRAM_A] <= merge(mem[SRAM_A], SRAM_DI, SRAM_WEB);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: SRAM writes, R beats and B responses are popped against the scoreboards.
    always @(negedge ACLK) begin
        if (SRAM_CS === 1'b1 && SRAM_WEB !== 4'hF) begin
            checks++;
            assert (exp_wr.size() != 0) else begin
                errors++;
                $error("FAIL sram_wr_unexpected: got A=%h DI=%h WEB=%h expected no write", SRAM_A, SRAM_DI, SRAM_WEB);
            end
            if (exp_wr.size() != 0) begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("sram_a", 32'(SRAM_A), 32'(e.a));
                chk("sram_di", SRAM_DI, e.d);
                chk("sram_web", 32'(SRAM_WEB), 32'(e.web));
            end
        end
        if (RVALID === 1'b1 && RREADY) begin
            r_cnt++;
            checks++;
            assert (exp_r.size() != 0) else begin
                errors++;
                $error("FAIL r_unexpected: got RDATA=%h expected no beat", RDATA);
            end
            if (exp_r.size() != 0) begin
                rd_t e;
                e = exp_r.pop_front();
                chk("rdata", RDATA, e.d);
                chk("rid", 32'(RID), 32'(e.id));
                chk("rlast", 32'(RLAST), 32'(e.last));
                chk("rresp", 32'(RRESP), 32'(e.resp));
            end
        end
        if (BVALID === 1'b1 && BREADY) begin
            b_cnt++;
            b_cyc = cyc;
            checks++;
            assert (exp_b.size() != 0) else begin
                errors++;
                $error("FAIL b_unexpected: got BID=%h expected no response", BID);
            end
            if (exp_b.size() != 0) begin
                b_t e;
                e = exp_b.pop_front();
                chk("bid", 32'(BID), 32'(e.id));
                chk("bresp", 32'(BRESP), 32'(e.resp));
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [3:0] len, input logic [IDW-1:0] id,
                         input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        logic [SRAM_AW-1:0] a;
        ok = 0;
        ARADDR = addr; ARLEN = len; ARID = id; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge ACLK);
            if (ARREADY) begin ok = 1; ar_cyc = cyc; end
            tick();
        end
        ARVALID = 1'b0;
        checks++;
        assert (ok) else begin errors++; $error("FAIL ar_timeout: got no ARREADY expected handshake"); end
        a = addr[SRAM_AW+1:2];
        for (int i = 0; i <= int'(len); i++) begin
            exp_r.push_back('{shadow[a], id, (i == int'(len)), (size != SIZE_WORD) ? RESP_SLVERR : RESP_OKAY});
            a = step_a(a, burst);
        end
    endtask

    task automatic do_aw(input logic [31:0] addr, input logic [3:0] len, input logic [IDW-1:0] id,
                         input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok = 0;
        AWADDR = addr; AWLEN = len; AWID = id; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge ACLK);
            if (AWREADY) ok = 1;
            tick();
        end
        AWVALID = 1'b0;
        checks++;
        assert (ok) else begin errors++; $error("FAIL aw_timeout: got no AWREADY expected handshake"); end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [IDW-1:0] id,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats);
        logic [SRAM_AW-1:0] a;
        int c0;
        a = addr[SRAM_AW+1:2];
        for (int i = 0; i < nbeats; i++) begin
            if (i <= int'(len)) begin
                exp_wr.push_back('{a, wd[i], ~ws[i]});
                shadow[a] = merge(shadow[a], wd[i], ~ws[i]);
            end
            a = step_a(a, burst);
        end
        exp_b.push_back('{id, (size != SIZE_WORD || nbeats != int'(len) + 1) ? RESP_SLVERR : RESP_OKAY});
        do_aw(addr, len, id, size, burst);
        c0 = cyc;
        for (int i = 0; i < nbeats; i++) begin
            bit ok;
            ok = 0;
            WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == nbeats - 1); WVALID = 1'b1;
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge ACLK);
                if (WREADY) ok = 1;
                tick();
            end
            checks++;
            assert (ok) else begin errors++; $error("FAIL w_timeout: got no WREADY expected handshake"); end
        end
        WVALID = 1'b0; WLAST = 1'b0;
        w_cycles = cyc - c0;
    endtask

    task automatic wait_r(input int target);
        int n;
        n = 0;
        while (r_cnt < target && n < 100) begin tick(); n++; end
        checks++;
        assert (r_cnt >= target) else begin errors++; $error("FAIL r_timeout: got %0d beats expected %0d", r_cnt, target); end
    endtask

    task automatic wait_b(input int target);
        int n;
        n = 0;
        while (b_cnt < target && n < 100) begin tick(); n++; end
        checks++;
        assert (b_cnt >= target) else begin errors++; $error("FAIL b_timeout: got %0d responses expected %0d", b_cnt, target); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int rt, bt;
        for (int i = 0; i < (1 << SRAM_AW); i++) begin
            mem[i]    <= {16'(i) ^ 16'hA5A5, ~16'(i)};
            shadow[i]  = {16'(i) ^ 16'hA5A5, ~16'(i)};
        end
        mem[4]   <= 32'hDEADBEEF;
        shadow[4] = 32'hDEADBEEF;

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(AWREADY), 0);
        chk("rst_arready", 32'(ARREADY), 0);
        chk("rst_wready", 32'(WREADY), 0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_bvalid", 32'(BVALID), 0);
        chk("rst_cs", 32'(SRAM_CS), 0);
        chk("rst_oe", 32'(SRAM_OE), 0);
        chk("rst_web", 32'(SRAM_WEB), 32'hF);
        chk("rst_a", 32'(SRAM_A), 0);
        chk("rst_rdata", RDATA, 0);
        ARESETn = 1'b1;
        tick();
        chk("post_rst_awready", 32'(AWREADY), 1);
        chk("post_rst_arready", 32'(ARREADY), 1);

        // Single read with latency check
        rt = r_cnt + 1;
        do_ar(32'h10, 4'd0, 8'h21, SIZE_WORD, BURST_INCR);
        @(negedge ACLK); chk("rd_lat_c1", 32'(RVALID), 0);
        @(negedge ACLK); chk("rd_lat_c2", 32'(RVALID), 0);
        @(negedge ACLK); chk("rd_lat_c3", 32'(RVALID), 1);
        tick();
        wait_r(rt);

        // INCR 4-beat write, partial strobe on beat 2
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h1111_0000 + 32'(i); ws[i] = 4'hF; end
        ws[2] = 4'b0011;
        bt = b_cnt + 1;
        do_write(32'h40, 4'd3, 8'h33, SIZE_WORD, BURST_INCR, 4);
        chk("w_throughput", 32'(w_cycles), 4);
        chk("bvalid_after_wlast", 32'(BVALID), 1);
        wait_b(bt);

        // Simultaneous AW/AR: write wins, read waits for B then sees the new data
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        bt = b_cnt + 1; rt = r_cnt + 1;
        fork
            do_write(32'h100, 4'd0, 8'h12, SIZE_WORD, BURST_INCR, 1);
            do_ar(32'h100, 4'd0, 8'h77, SIZE_WORD, BURST_INCR);
            begin @(negedge ACLK); chk("sim_arready_low", 32'(ARREADY), 0); end
        join
        wait_b(bt);
        wait_r(rt);
        chk("ar_after_b", 32'(ar_cyc > b_cyc), 1);

        // Backpressure on second beat of a 2-beat read
        RREADY = 1'b0;
        rt = r_cnt + 2;
        do_ar(32'h80, 4'd1, 8'h5A, SIZE_WORD, BURST_INCR);
        for (int i = 0; i < 20 && RVALID !== 1'b1; i++) tick();
        RREADY = 1'b1; tick(); RREADY = 1'b0;
        for (int i = 0; i < 20 && RVALID !== 1'b1; i++) tick();
        begin
            int cs0;
            cs0 = cs_cnt;
            for (int i = 0; i < 5; i++) begin
                @(negedge ACLK);
                chk("bp_rvalid", 32'(RVALID), 1);
                chk("bp_rdata", RDATA, shadow[14'h21]);
                chk("bp_rid", 32'(RID), 32'h5A);
                chk("bp_rlast", 32'(RLAST), 1);
            end
            chk("bp_no_sram", 32'(cs_cnt - cs0), 0);
        end
        tick();
        RREADY = 1'b1;
        wait_r(rt);

        // Early WLAST: AWLEN 3, WLAST on beat 1
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h2222_0000 + 32'(i); ws[i] = 4'hF; end
        bt = b_cnt + 1;
        do_write(32'h300, 4'd3, 8'h44, SIZE_WORD, BURST_INCR, 2);
        wait_b(bt);

        // FIXED 3-beat write
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h3333_0000 + 32'(i); ws[i] = 4'hF; end
        bt = b_cnt + 1;
        do_write(32'h140, 4'd2, 8'h45, SIZE_WORD, BURST_FIXED, 3);
        wait_b(bt);

        // INCR wrap at the top of the SRAM
        for (int i = 0; i < 2; i++) begin wd[i] = 32'h4444_0000 + 32'(i); ws[i] = 4'hF; end
        bt = b_cnt + 1;
        do_write(32'h0000_FFFC, 4'd1, 8'h46, SIZE_WORD, BURST_INCR, 2);
        wait_b(bt);

        // Late WLAST: AWLEN 1, three beats; the extra beat must not be written
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h5555_0000 + 32'(i); ws[i] = 4'hF; end
        bt = b_cnt + 1;
        do_write(32'h400, 4'd1, 8'h47, SIZE_WORD, BURST_INCR, 3);
        wait_b(bt);

        // Unsupported size on a WRAP read: data returned, every beat SLVERR
        rt = r_cnt + 2;
        do_ar(32'h400, 4'd1, 8'h66, 3'b001, BURST_WRAP);
        wait_r(rt);

        // Reset pulsed during beat 2 of an 8-beat write
        for (int i = 0; i < 3; i++) begin wd[i] = 32'h6666_0000 + 32'(i); ws[i] = 4'hF; end
        for (int i = 0; i < 2; i++) begin
            exp_wr.push_back('{SRAM_AW'(14'h80 + i), wd[i], 4'h0});
            shadow[14'h80 + i] = wd[i];
        end
        do_aw(32'h200, 4'd7, 8'h55, SIZE_WORD, BURST_INCR);
        for (int i = 0; i < 2; i++) begin
            WDATA = wd[i]; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
            tick();
        end
        WDATA = wd[2]; WVALID = 1'b1;
        #2;
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_awready", 32'(AWREADY), 0);
        chk("mid_rst_wready", 32'(WREADY), 0);
        chk("mid_rst_bvalid", 32'(BVALID), 0);
        chk("mid_rst_cs", 32'(SRAM_CS), 0);
        chk("mid_rst_web", 32'(SRAM_WEB), 32'hF);
        chk("mid_rst_a", 32'(SRAM_A), 0);
        chk("mid_rst_di", SRAM_DI, 0);
        chk("mid_rst_bid", 32'(BID), 0);
        chk("mid_rst_rid", 32'(RID), 0);
        WVALID = 1'b0;
        tick(); tick();
        ARESETn = 1'b1;
        tick();
        wd[0] = 32'h7777_0001; ws[0] = 4'hF;
        bt = b_cnt + 1;
        do_write(32'h240, 4'd0, 8'h56, SIZE_WORD, BURST_INCR, 1);
        wait_b(bt);
        rt = r_cnt + 3;
        do_ar(32'h200, 4'd2, 8'h57, SIZE_WORD, BURST_INCR);
        wait_r(rt);

        repeat (3) tick();
        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        chk("r_queue_empty", 32'(exp_r.size()), 0);
        chk("b_queue_empty", 32'(exp_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
